// File: rtl/pwm_dac.sv
// pwm_dac: windowed PWM DAC. A free-running window counter compares against a
// duty value that is latched once per window from the upstream sample code.
//
// Optional feature: define PWM_DAC_VOLUME_EN to add the vol_shift input, which
// scales the sample toward mid-scale before it is latched.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   enable      1 = window advances, 0 = hold all state
//   code        unsigned sample code from upstream
//   vol_shift   (PWM_DAC_VOLUME_EN only) arithmetic attenuation shift
//   next_sample combinational one-cycle strobe requesting the next sample
//   pwm_out     registered PWM bit
//   duty        currently latched duty value (debug)
module pwm_dac #(
  parameter int unsigned CODE_WIDTH        = 10,
  parameter int unsigned CYCLES_PER_WINDOW = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CODE_WIDTH-1:0] code,
`ifdef PWM_DAC_VOLUME_EN
  input  logic [2:0]            vol_shift,
`endif
  output logic                  next_sample,
  output logic                  pwm_out,
  output logic [CODE_WIDTH-1:0] duty
);

  localparam int unsigned CNT_W = (CYCLES_PER_WINDOW > 1) ? $clog2(CYCLES_PER_WINDOW) : 1;
  localparam int unsigned CMP_W = (CNT_W > CODE_WIDTH) ? CNT_W : CODE_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_WINDOW - 1);

  logic [CNT_W-1:0]      cnt;
  logic                  last_c;
  logic                  wrap_c;
  logic [CODE_WIDTH-1:0] duty_next_c;

  // End-of-window detect; enable gates it so a pause in the last cycle neither strobes nor loads.
  always_comb begin
    last_c      = (cnt == CNT_LAST);
    wrap_c      = enable && last_c;
    next_sample = rst && wrap_c;
  end

`ifdef PWM_DAC_VOLUME_EN
  localparam int unsigned SW = CODE_WIDTH + 1;
  localparam logic signed [SW-1:0] MID = SW'(2 ** (CODE_WIDTH - 1));

  logic signed [SW-1:0] diff_c;
  logic signed [SW-1:0] shifted_c;
  logic signed [SW-1:0] sum_c;

  // Scale the sample's offset from mid-scale; result always lands back in code range.
  always_comb begin
    diff_c      = $signed({1'b0, code}) - MID;
    shifted_c   = diff_c >>> vol_shift;
    sum_c       = shifted_c + MID;
    duty_next_c = sum_c[CODE_WIDTH-1:0];
  end
`else
  // Sample passes straight through to the duty register.
  always_comb begin
    duty_next_c = code;
  end
`endif

  // Window counter, per-window duty latch and registered compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else if (enable) begin
      cnt     <= last_c ? '0 : cnt + CNT_W'(1);
      pwm_out <= (CMP_W'(cnt) < CMP_W'(duty));
      if (last_c) begin
        duty <= duty_next_c;
      end
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed self-checking bench for pwm_dac (CODE_WIDTH=10,
// CYCLES_PER_WINDOW=1024). Outputs are sampled 1 time unit after each rising edge.
// The volume sequence runs only when PWM_DAC_VOLUME_EN is defined.
module tb_pwm_dac;

  localparam int unsigned CW  = 10;
  localparam int unsigned CPW = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] code;
`ifdef PWM_DAC_VOLUME_EN
  logic [2:0]    vol_shift;
`endif
  logic          next_sample;
  logic          pwm_out;
  logic [CW-1:0] duty;

  pwm_dac #(.CODE_WIDTH(CW), .CYCLES_PER_WINDOW(CPW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .code        (code),
`ifdef PWM_DAC_VOLUME_EN
    .vol_shift   (vol_shift),
`endif
    .next_sample (next_sample),
    .pwm_out     (pwm_out),
    .duty        (duty)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc;
  int   ns_cnt, hi, first, last, hi0, hi1, lo1, pchg, n;
  logic exp_ns;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

`ifdef PWM_DAC_VOLUME_EN
  task automatic load_window(input logic [CW-1:0] c, input logic [2:0] vs, input int unsigned exp_duty);
    code      = c;
    vol_shift = vs;
    n = 0;
    while (!next_sample && n < 1100) begin
      tick();
      n++;
    end
    check("vol_wrap_seen", next_sample, 1);
    tick();
    check("vol_duty", duty, exp_duty);
  endtask
`endif

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    code   = '0;
`ifdef PWM_DAC_VOLUME_EN
    vol_shift = 3'd0;
`endif
    cyc = 0;
    ns_cnt = 0; hi = 0; first = -1; last = -1; hi0 = 0; hi1 = 0; lo1 = 0; pchg = 0;

    // Reset state before any clock edge.
    #3;
    check("rst_duty", duty, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_ns", next_sample, 0);

    // Release, code=300 held: strobes at 1023/2047/3071, second window 300 high.
    repeat (3) tick();
    rst = 1'b1; enable = 1'b1; code = 10'd300; cyc = 0;
    for (int k = 1; k <= 3100; k++) begin
      tick();
      exp_ns = ((k % 1024) == 1023);
      if (next_sample || exp_ns) check("strobe", next_sample, exp_ns);
      if (next_sample) ns_cnt++;
      if (k == 1023) check("duty_before_wrap", duty, 0);
      if (k == 1024) check("duty_300", duty, 300);
      if (k >= 1024 && k <= 2047 && pwm_out) begin
        hi++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check("strobe_count", ns_cnt, 3);
    check("hi_300", hi, 300);
    check("hi_first", first, 1025);
    check("hi_last", last, 1324);

    // Extremes: code=0 window all low, code=1023 window 1023 high / 1 low.
    code = 10'd0;
    while (cyc < 6144) begin
      tick();
      if (cyc == 4096) check("duty_0", duty, 0);
      if (cyc == 4500) code = 10'd1023;
      if (cyc == 5120) check("duty_1023", duty, 1023);
      if (cyc >= 4097 && cyc <= 5120 && pwm_out) hi0++;
      if (cyc >= 5121 && cyc <= 6144) begin
        if (pwm_out) hi1++;
        else lo1++;
      end
    end
    check("zero_hi", hi0, 0);
    check("full_hi", hi1, 1023);
    check("full_lo", lo1, 1);

    // Pause at cnt=500 for 37 cycles.
    while (cyc < 6644) tick();
    enable = 1'b0;
    code   = 10'd300;
    repeat (37) begin
      tick();
      if (next_sample) check("pause_strobe", next_sample, 0);
      if (pwm_out !== 1'b1) pchg++;
    end
    check("pause_pwm_frozen", pchg, 0);
    check("pause_duty", duty, 1023);
    enable = 1'b1;
    n = 0;
    while (!next_sample && n < 2000) begin
      tick();
      n++;
    end
    check("pause_strobe_cycle", cyc, 7204);

    // Enable dropped in the strobe cycle: no strobe, no load.
    enable = 1'b0;
    #1;
    check("ns_gated", next_sample, 0);
    repeat (3) tick();
    check("gated_no_load", duty, 1023);
    enable = 1'b1;
    #1;
    check("ns_resume", next_sample, 1);
    tick();
    check("resume_load", duty, 300);

    // Asynchronous reset at cnt=700.
    repeat (700) tick();
    check("duty_pre_rst", duty, 300);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_duty", duty, 0);
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_ns", next_sample, 0);
    repeat (2) tick();
    rst = 1'b1; code = 10'd1023;
    for (int k = 1; k <= 1023; k++) begin
      tick();
      if (next_sample && k != 1023) check("rst_early_strobe", next_sample, 0);
    end
    check("rst_first_strobe", next_sample, 1);
    check("rst_duty_hold", duty, 0);
    tick();
    check("rst_first_load", duty, 1023);

`ifdef PWM_DAC_VOLUME_EN
    load_window(10'd1023, 3'd1, 767);
    load_window(10'd0,    3'd1, 256);
    load_window(10'd1023, 3'd0, 1023);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
